// File: rtl/mux_nx1_pkg.sv
// mux_nx1_pkg: shared definitions for the N:1 stream multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   wrap_inc             : index increment that wraps from n-1 back to 0
package mux_nx1_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_pick.sv
// mux_nx1_rr_pick: rotating-priority finder, purely combinational.
//   req       in  N     request vector
//   ptr       in  SELW  highest-priority index (must be < N)
//   gnt_valid out 1     some request was found
//   gnt_idx   out SELW  first requesting index at or after ptr, wrapping mod N
module mux_nx1_rr_pick #(
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int w_idx;

  // Walk from the lowest priority offset to the highest so that the
  // last hit (offset 0 nearest ptr) is what remains.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(ptr) + k) % N;
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N:1 channel multiplexer with a registered output stage
// and valid/ready handshakes on every channel and on the output.
//   clk, rst             clock; synchronous active-high reset
//   mode                 0 = fixed select via sel, 1 = round-robin among valid inputs
//   sel                  channel index used in fixed mode (>= N means no grant)
//   in_data/valid/last   N producer channels; channel i at in_data[i*W +: W]
//   in_ready             per-channel ready, one-hot or zero
//   out_data/src/valid   registered output word, its source channel, and valid
//   out_ready            consumer accepts the word
// Optional build macro MUX_NX1_LOCK_EN: in round-robin mode, a channel that
// starts a packet keeps the grant until it transfers a beat with in_last=1.
module mux_nx1_stream
  import mux_nx1_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_src;
  logic            r_out_valid;
  logic [SELW-1:0] r_ptr;

  logic            w_load;
  logic            w_fx_ok;
  logic [N-1:0]    w_rr_req;
  logic            w_rr_ok;
  logic [SELW-1:0] w_rr_idx;
  logic            w_gnt;
  logic [SELW-1:0] w_g;
  logic [W-1:0]    w_word;

  // Output register can take a word when empty or when its word leaves now.
  assign w_load = ~r_out_valid | out_ready;

  // Fixed mode: an out-of-range sel simply never grants.
  always_comb begin
    w_fx_ok = 1'b0;
    if (int'(sel) < N) w_fx_ok = in_valid[sel];
  end

`ifdef MUX_NX1_LOCK_EN
  logic            r_lock_vld;
  logic [SELW-1:0] r_lock_idx;
  // A locked channel is the only candidate; if it is idle, nobody is granted.
  assign w_rr_req = r_lock_vld ? (in_valid & (N'(1) << r_lock_idx)) : in_valid;
`else
  logic w_unused_last;
  assign w_unused_last = ^in_last;
  assign w_rr_req      = in_valid;
`endif

  mux_nx1_rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req       (w_rr_req),
    .ptr       (r_ptr),
    .gnt_valid (w_rr_ok),
    .gnt_idx   (w_rr_idx)
  );

  assign w_g      = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_gnt    = w_load & ((mode == MODE_RR) ? w_rr_ok : w_fx_ok);
  assign in_ready = w_gnt ? (N'(1) << w_g) : '0;
  assign w_word   = in_data[w_g*W +: W];

  // A grant always coincides with in_valid[g], so w_gnt is the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_gnt;
      if (w_gnt) begin
        r_out_data <= w_word;
        r_out_src  <= w_g;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_gnt && mode == MODE_RR) begin
`ifdef MUX_NX1_LOCK_EN
      if (in_last[w_g]) r_ptr <= SELW'(wrap_inc(int'(w_g), N));
`else
      r_ptr <= SELW'(wrap_inc(int'(w_g), N));
`endif
    end
  end

`ifdef MUX_NX1_LOCK_EN
  // Any cycle spent in fixed mode drops the lock, which covers every mode change.
  always_ff @(posedge clk) begin
    if (rst || mode == MODE_FIXED) begin
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_gnt) begin
      r_lock_vld <= ~in_last[w_g];
      r_lock_idx <= w_g;
    end
  end
`endif

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nx1_stream.sv
module tb_mux_nx1_stream;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_valid, out_ready;

  // Second instance with N=5 so that sel can point past the last channel.
  logic [2:0]     sel5;
  logic [5*W-1:0] in_data5;
  logic [4:0]     in_valid5, in_ready5;
  logic [W-1:0]   out_data5;
  logic [2:0]     out_src5;
  logic           out_valid5;

  int checks = 0, failures = 0;

  // Reference model state
  logic       m_vld;
  logic [7:0] m_data;
  int         m_src, m_ptr, m_lock_idx;
  logic       m_lock;

  always #5 clk = ~clk;

  mux_nx1_stream #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nx1_stream #(.N(5), .W(W)) u_dut5 (
    .clk(clk), .rst(rst), .mode(1'b0), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_last(5'b0), .in_ready(in_ready5),
    .out_data(out_data5), .out_src(out_src5), .out_valid(out_valid5), .out_ready(1'b1)
  );

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model grant decision from the current inputs and model state.
  task model_grant(output bit ok, output int g);
    bit load;
    load = !m_vld || out_ready;
    ok = 0; g = 0;
    if (!load) return;
    if (mode == 1'b0) begin
      g  = int'(sel);
      ok = (g < N) && in_valid[g];
    end else if (m_lock) begin
      g  = m_lock_idx;
      ok = in_valid[g];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!ok && in_valid[c]) begin ok = 1; g = c; end
      end
    end
  endtask

  // One clock: check in_ready now, advance model at the edge, check outputs.
  task step();
    bit ok; int g;
    logic [N-1:0] exp_rdy;
    #1;
    model_grant(ok, g);
    exp_rdy = '0;
    if (ok && !rst) exp_rdy[g] = 1'b1;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = 0; m_src = 0; m_ptr = 0; m_lock = 0; m_lock_idx = 0;
    end else begin
      if (!m_vld || out_ready) begin
        m_vld = ok;
        if (ok) begin
          m_data = in_data[g*W +: W];
          m_src  = g;
          if (mode) begin
`ifdef MUX_NX1_LOCK_EN
            if (in_last[g]) begin m_lock = 0; m_ptr = (g + 1) % N; end
            else begin m_lock = 1; m_lock_idx = g; end
`else
            m_ptr = (g + 1) % N;
`endif
          end
        end
      end
      if (!mode) m_lock = 0;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_src", 32'(out_src), 32'(m_src));
    end
  endtask

  task set_rr_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
  endtask

  initial begin
    int exp_seq[6];
    int exp6[4];
    rst = 1; mode = 0; sel = 0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1;
    sel5 = 0; in_data5 = '0; in_valid5 = '0;
    m_vld = 0; m_data = 0; m_src = 0; m_ptr = 0; m_lock = 0; m_lock_idx = 0;
    @(negedge clk);

    // 1. Reset, then a fixed-mode word from channel 2
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 0; sel = 2; in_valid = 4'b0100; in_data[2*W +: W] = 8'hA5;
    step();
    chk("t1_data", 32'(out_data), 32'h A5);
    chk("t1_src", 32'(out_src), 2);

    // 2. Backpressure holds the word; release gives one word per cycle
    out_ready = 0; in_data[2*W +: W] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold", 32'(out_data), 32'h A5);
      chk("t2_rdy", 32'(in_ready), 0);
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_data[2*W +: W] = 8'(8'h60 + i);
      step();
      chk("t2_stream", 32'(out_data), 32'(8'h60 + i));
    end

    // 3. sel beyond the last channel never grants (N=5 instance)
    sel5 = 4; in_valid5 = 5'b10000; in_data5[4*W +: W] = 8'h3C;
    @(posedge clk); @(negedge clk);
    chk("t3_load", 32'({out_valid5, out_data5}), 32'h13C);
    chk("t3_src", 32'(out_src5), 4);
    sel5 = 5; in_valid5 = 5'b11111;
    #1 chk("t3_no_rdy", 32'(in_ready5), 0);
    @(posedge clk); @(negedge clk);
    chk("t3_drain", 32'(out_valid5), 0);
    chk("t3_data_held", 32'(out_data5), 32'h3C);
    in_valid5 = '0;

    // 4. Round-robin over all valid channels, pointer wraps
    mode = 1; in_valid = 4'b1111; set_rr_data();
    exp_seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_src", 32'(out_src), 32'(exp_seq[i]));
    end

    // 5. Sparse round-robin from ptr=0, then channel 3 drops out
    rst = 1; step(); rst = 0;
    in_valid = 4'b1010;
    exp_seq = '{1, 3, 1, 3, 1, 1};
    for (int i = 0; i < 6; i++) begin
      if (i == 4) in_valid = 4'b0010;
      step();
      chk("t5_src", 32'(out_src), 32'(exp_seq[i]));
    end

    // 6. Channel 0 sends a 3-beat packet while channel 1 competes
    rst = 1; step(); rst = 0;
    in_valid = 4'b0011;
`ifdef MUX_NX1_LOCK_EN
    exp6 = '{0, 0, 0, 1};
`else
    exp6 = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2) ? 4'b0011 : 4'b0010;
      step();
      chk("t6_src", 32'(out_src), 32'(exp6[i]));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = ($urandom_range(0, 9) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
